// File: rtl/polyphase_combiner_if.sv
// Stream bundle for polyphase_combiner: branch-result input side and
// buffered combined-sample output side.
interface polyphase_combiner_if #(
  parameter int SAMPLE_WIDTH = 16
);
  logic                           valid_in;
  logic signed [SAMPLE_WIDTH-1:0] data_in;
  logic                           sync_in;
  logic                           ready_in;
  logic                           valid_out;
  logic signed [SAMPLE_WIDTH-1:0] data_out;

  // Producer/consumer environment around the combiner.
  modport master (
    output valid_in, data_in, sync_in, ready_in,
    input  valid_out, data_out
  );

  // The combiner itself.
  modport slave (
    input  valid_in, data_in, sync_in, ready_in,
    output valid_out, data_out
  );
endinterface

// File: rtl/polyphase_combiner.sv
// Polyphase combiner: sums M consecutive branch results into one output
// sample, saturates it to SAMPLE_WIDTH and queues it in a small FIFO.
module polyphase_combiner #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int M            = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  polyphase_combiner_if.slave   bus,
  output logic                  overrun,
  output logic                  saturated
);

  localparam int AW  = SAMPLE_WIDTH + $clog2(M) + 1;
  localparam int PW  = (M > 1) ? $clog2(M) : 1;
  localparam int FAW = $clog2(FIFO_DEPTH);

  localparam logic [PW-1:0]        LAST_PHASE = PW'(M - 1);
  localparam logic [FAW:0]         FULL_COUNT = (FAW + 1)'(FIFO_DEPTH);
  localparam logic signed [AW-1:0] SAT_MAX =
    {{(AW - SAMPLE_WIDTH + 1){1'b0}}, {(SAMPLE_WIDTH - 1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN =
    {{(AW - SAMPLE_WIDTH + 1){1'b1}}, {(SAMPLE_WIDTH - 1){1'b0}}};

  logic [PW-1:0]                  phase;
  logic [PW-1:0]                  eff_phase;
  logic                           is_last;
  logic signed [AW-1:0]           acc;
  logic signed [AW-1:0]           sample_ext;
  logic signed [AW-1:0]           sum;
  logic signed [SAMPLE_WIDTH-1:0] sat_val;
  logic                           clip;

  logic signed [SAMPLE_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [FAW-1:0]                 wr_ptr;
  logic [FAW-1:0]                 rd_ptr;
  logic [FAW:0]                   count;
  logic                           push;
  logic                           pop;
  logic                           full;
  logic                           accept;

  // Phase resolution, running sum, saturation and FIFO handshake decode.
  always_comb begin
    sample_ext = {{(AW - SAMPLE_WIDTH){bus.data_in[SAMPLE_WIDTH-1]}}, bus.data_in};
    // A sync marker restarts the frame: the sample is branch 0 whatever the counter says.
    eff_phase  = bus.sync_in ? '0 : phase;
    is_last    = (eff_phase == LAST_PHASE);
    sum        = (eff_phase == '0) ? sample_ext : acc + sample_ext;
    clip       = 1'b0;
    sat_val    = sum[SAMPLE_WIDTH-1:0];
    if (sum > SAT_MAX) begin
      clip    = 1'b1;
      sat_val = SAT_MAX[SAMPLE_WIDTH-1:0];
    end else if (sum < SAT_MIN) begin
      clip    = 1'b1;
      sat_val = SAT_MIN[SAMPLE_WIDTH-1:0];
    end
    full          = (count == FULL_COUNT);
    bus.valid_out = (count != '0);
    bus.data_out  = bus.valid_out ? mem[rd_ptr] : '0;
    pop           = bus.valid_out && bus.ready_in;
    push          = bus.valid_in && is_last;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    accept        = push && (!full || pop);
  end

  // Phase counter and accumulator advance only on valid input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase <= '0;
      acc   <= '0;
    end else if (bus.valid_in) begin
      acc   <= sum;
      phase <= is_last ? '0 : eff_phase + 1'b1;
    end
  end

  // FIFO pointers, occupancy and sticky status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overrun   <= 1'b0;
      saturated <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && !accept) overrun <= 1'b1;
      if (push && clip)    saturated <= 1'b1;
    end
  end

  // FIFO storage; contents are only observable through the occupancy-gated head.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= sat_val;
  end

endmodule

// File: tb/tb_polyphase_combiner.sv
// Randomized and directed bench for polyphase_combiner against a queue-based
// reference model of the combine/saturate/buffer behaviour.
module tb_polyphase_combiner;

  localparam int SW    = 16;
  localparam int MM    = 2;
  localparam int DEPTH = 4;
  localparam longint SMAX = (longint'(1) <<< (SW - 1)) - 1;
  localparam longint SMIN = -(longint'(1) <<< (SW - 1));

  logic clk = 1'b0;
  logic rst;
  logic overrun;
  logic saturated;

  polyphase_combiner_if #(.SAMPLE_WIDTH(SW)) dif ();

  polyphase_combiner #(
    .SAMPLE_WIDTH(SW),
    .M(MM),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (rst),
    .bus      (dif.slave),
    .overrun  (overrun),
    .saturated(saturated)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  longint q[$];
  int     m_phase;
  longint m_psum;
  bit     m_ovr;
  bit     m_sat;

  task automatic check(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_phase = 0;
    m_psum  = 0;
    m_ovr   = 0;
    m_sat   = 0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".valid"}, longint'(dif.valid_out), longint'(q.size() != 0));
    if (q.size() != 0)
      check({tag, ".data"}, longint'($signed(dif.data_out)), q[0]);
    check({tag, ".ovr"}, longint'(overrun), longint'(m_ovr));
    check({tag, ".sat"}, longint'(saturated), longint'(m_sat));
  endtask

  // One clock: drive inputs, let the edge happen, update model, compare.
  task automatic step(input bit v, input int d, input bit s, input bit r, input string tag);
    bit     do_pop;
    longint full_sum;
    dif.valid_in = v;
    dif.data_in  = SW'(d);
    dif.sync_in  = s;
    dif.ready_in = r;
    @(posedge clk);
    do_pop = (q.size() != 0) && r;
    if (do_pop) void'(q.pop_front());
    if (v) begin
      if (s) m_phase = 0;
      full_sum = (m_phase == 0) ? longint'(d) : m_psum + longint'(d);
      m_psum   = full_sum;
      if (m_phase == MM - 1) begin
        if (full_sum > SMAX) begin full_sum = SMAX; m_sat = 1; end
        if (full_sum < SMIN) begin full_sum = SMIN; m_sat = 1; end
        if (q.size() < DEPTH) q.push_back(full_sum);
        else m_ovr = 1;
        m_phase = 0;
      end else begin
        m_phase++;
      end
    end
    #1;
    check_outputs(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    dif.valid_in = 1'b0;
    dif.data_in  = '0;
    dif.sync_in  = 1'b0;
    dif.ready_in = 1'b0;
    rst          = 1'b1;
    model_reset();
    #12;
    check("rst.valid", longint'(dif.valid_out), 0);
    check("rst.data", longint'($signed(dif.data_out)), 0);
    check("rst.ovr", longint'(overrun), 0);
    check("rst.sat", longint'(saturated), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic pair.
    step(1, 100, 0, 1, "pair0");
    step(1, 200, 0, 1, "pair1");
    check("pair.data300", longint'($signed(dif.data_out)), 300);
    step(0, 0, 0, 1, "pair_drain");
    check("pair.one_cycle", longint'(dif.valid_out), 0);

    // Saturation both directions.
    step(1, 30000, 0, 1, "sat0");
    step(1, 10000, 0, 1, "sat1");
    check("sat.hi", longint'($signed(dif.data_out)), 32767);
    step(1, -30000, 0, 1, "sat2");
    step(1, -10000, 0, 1, "sat3");
    check("sat.lo", longint'($signed(dif.data_out)), -32768);
    check("sat.flag", longint'(saturated), 1);
    step(0, 0, 0, 1, "sat_drain");

    // Backpressure with overflow.
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      step(1, i, 0, 0, "bp_a");
      step(1, i, 0, 0, "bp_b");
      if (i == 4) check("bp.head2", longint'($signed(dif.data_out)), 2);
    end
    check("bp.overrun", longint'(overrun), 1);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, "bp_drain");
    check("bp.empty", longint'(dif.valid_out), 0);

    // Full FIFO with simultaneous push and pop.
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      step(1, i, 0, 0, "fp_a");
      step(1, i, 0, 0, "fp_b");
    end
    step(1, 7, 0, 0, "fp_c");
    step(1, 7, 0, 1, "fp_d");
    check("fp.noovr", longint'(overrun), 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, "fp_drain");

    // Realignment by sync.
    step(1, 10, 1, 1, "al0");
    step(1, 20, 0, 1, "al1");
    check("al.30", longint'($signed(dif.data_out)), 30);
    step(1, 30, 0, 1, "al2");
    step(1, 40, 1, 1, "al3");
    step(1, 50, 0, 1, "al4");
    check("al.90", longint'($signed(dif.data_out)), 90);
    step(0, 0, 0, 1, "al_idle");

    // Asynchronous reset between edges while output valid.
    step(1, 1, 0, 0, "ar0");
    step(1, 2, 0, 0, "ar1");
    #3;
    rst = 1'b1;
    #1;
    check("arst.valid", longint'(dif.valid_out), 0);
    check("arst.data", longint'($signed(dif.data_out)), 0);
    #1;
    rst = 1'b0;
    model_reset();
    step(1, 5, 0, 1, "ar2");
    step(1, 6, 0, 1, "ar3");
    check("arst.11", longint'($signed(dif.data_out)), 11);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      bit v, s, r;
      int d;
      v = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 7) == 0);
      r = ($urandom_range(0, 1) == 1);
      d = int'($urandom_range(0, 40000)) - 20000;
      step(v, d, s, r, "rand");
    end
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1, "rand_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
